// File: rtl/uncache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uncache_pkg
// Brief    : Source IDs, size encodings and FSM states for the uncache arbiter.
// Revision : 1.0
// ============================================================================
package uncache_pkg;

    localparam logic [1:0] SRC_INST = 2'd0;
    localparam logic [1:0] SRC_DATA = 2'd1;
    localparam logic [1:0] SRC_SB   = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Round-robin successor over the three sources: inst -> data -> sb -> inst.
    function automatic logic [1:0] src_next(input logic [1:0] s);
        return (s == SRC_SB) ? SRC_INST : s + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uncache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uncache_arbiter_if
// Brief    : SRAM-like uncached bus between the arbiter and the AXI bridge.
// Revision : 1.0
// ============================================================================
interface uncache_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output rdata, addr_ok, data_ok
    );
endinterface
`default_nettype wire

// File: rtl/uncache_arbiter_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uncache_id_fifo
// Brief    : In-order FIFO of 2-bit source IDs for outstanding bus transactions.
// Revision : 1.0
// ============================================================================
module uncache_id_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     push,
    input  wire logic [1:0]               push_id,
    input  wire logic                     pop,
    output logic      [1:0]               head,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uncache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uncache_arbiter
// Brief    : Round-robin arbiter of inst fetch, uncached load and store drain
//            onto one SRAM-like bus, with in-order response routing.
//            Optional counters: define UNCACHE_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module uncache_arbiter
    import uncache_pkg::*;
#(
    parameter int OUTS_DEPTH = 4,
    parameter int RR_EN_INIT = 0
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        inst_req,
    input  wire logic [31:0] inst_addr,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    input  wire logic        data_req,
    input  wire logic [1:0]  data_size,
    input  wire logic [31:0] data_addr,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic      [31:0] rd_rdata,
    input  wire logic        sb_req,
    input  wire logic [1:0]  sb_size,
    input  wire logic [31:0] sb_addr,
    input  wire logic [31:0] sb_wdata,
    input  wire logic [3:0]  sb_wstrb,
    output logic             sb_addr_ok,
    output logic             sb_data_ok,
    input  wire logic        sb_pending,
    uncache_arbiter_if.master bus
`ifdef UNCACHE_ARB_PERF_EN
    ,
    output logic      [31:0] perf_sb_grants,
    output logic      [31:0] perf_ld_block
`endif
);
    localparam int AW = $clog2(OUTS_DEPTH);

    arb_state_e  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [AW:0] wr_out_q, wr_out_d;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [1:0]  fifo_head;
    logic [AW:0] fifo_count;

    logic [2:0]  req_vec, elig;
    logic        ld_order_block;
    logic        win_valid, sel_valid, accept;
    logic [1:0]  win, sel, cand;
    logic        sb_acc, sb_resp;

    uncache_id_fifo #(.DEPTH(OUTS_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .push_id (sel),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A load may not pass any store still in the buffer, on the wire, or unanswered.
    assign ld_order_block = sb_pending || sb_req || (wr_out_q != '0);
    assign req_vec = {sb_req, data_req, inst_req};
    assign elig    = {sb_req, data_req && !ld_order_block, inst_req} & {3{!fifo_full}};

    always_comb begin
        win_valid = 1'b0;
        win       = rr_q;
        cand      = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
            cand = src_next(cand);
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        sel_valid = 1'b0;
        sel       = gnt_q;
        case (state_q)
            ARB_IDLE: begin
                sel_valid = win_valid;
                sel       = win;
            end
            ARB_LOCK: begin
                sel_valid = req_vec[gnt_q];
                if (!req_vec[gnt_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        accept = sel_valid && bus.addr_ok;
        if (accept) begin
            rr_d    = src_next(sel);
            state_d = ARB_IDLE;
        end else if (sel_valid && (state_q == ARB_IDLE)) begin
            gnt_d   = sel;
            state_d = ARB_LOCK;
        end

        bus.req   = sel_valid;
        bus.wr    = sel_valid && (sel == SRC_SB);
        bus.size  = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        if (sel_valid) begin
            case (sel)
                SRC_INST: begin
                    bus.size = SZ_W;
                    bus.addr = inst_addr;
                end
                SRC_DATA: begin
                    bus.size = data_size;
                    bus.addr = data_addr;
                end
                SRC_SB: begin
                    bus.size  = sb_size;
                    bus.addr  = sb_addr;
                    bus.wdata = sb_wdata;
                    bus.wstrb = sb_wstrb;
                end
                default: ;
            endcase
        end
    end

    assign inst_addr_ok = accept && (sel == SRC_INST);
    assign data_addr_ok = accept && (sel == SRC_DATA);
    assign sb_addr_ok   = accept && (sel == SRC_SB);
    assign fifo_push    = accept;

    assign fifo_pop     = bus.data_ok && !fifo_empty;
    assign inst_data_ok = fifo_pop && (fifo_head == SRC_INST);
    assign data_data_ok = fifo_pop && (fifo_head == SRC_DATA);
    assign sb_data_ok   = fifo_pop && (fifo_head == SRC_SB);
    assign rd_rdata     = bus.rdata;

    assign sb_acc  = sb_addr_ok;
    assign sb_resp = sb_data_ok;

    always_comb begin
        wr_out_d = wr_out_q;
        case ({sb_acc, sb_resp})
            2'b10:   wr_out_d = wr_out_q + (AW+1)'(1);
            2'b01:   wr_out_d = wr_out_q - (AW+1)'(1);
            default: wr_out_d = wr_out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= SRC_INST;
            rr_q     <= 2'(RR_EN_INIT);
            wr_out_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            wr_out_q <= wr_out_d;
        end
    end

`ifdef UNCACHE_ARB_PERF_EN
    logic [31:0] perf_sb_q, perf_sb_d;
    logic [31:0] perf_ld_q, perf_ld_d;

    always_comb begin
        perf_sb_d = perf_sb_q;
        perf_ld_d = perf_ld_q;
        if (sb_acc && (perf_sb_q != '1)) begin
            perf_sb_d = perf_sb_q + 32'd1;
        end
        if (data_req && ld_order_block && (perf_ld_q != '1)) begin
            perf_ld_d = perf_ld_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_sb_q <= '0;
            perf_ld_q <= '0;
        end else begin
            perf_sb_q <= perf_sb_d;
            perf_ld_q <= perf_ld_d;
        end
    end

    assign perf_sb_grants = perf_sb_q;
    assign perf_ld_block  = perf_ld_q;
`endif

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rstn)
        !(bus.data_ok && fifo_empty));
    a_wr_out_bound: assert property (@(posedge clk) disable iff (!rstn)
        wr_out_q <= fifo_count);
endmodule
`default_nettype wire

// File: tb/tb_uncache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncache_arbiter
// Brief    : Directed self-checking bench with an in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uncache_arbiter;
    import uncache_pkg::*;

    logic        clk;
    logic        rstn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr;
    logic        data_req, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, rd_rdata;
    logic        sb_req, sb_addr_ok, sb_data_ok, sb_pending;
    logic [1:0]  sb_size;
    logic [31:0] sb_addr, sb_wdata;
    logic [3:0]  sb_wstrb;
`ifdef UNCACHE_ARB_PERF_EN
    logic [31:0] perf_sb_grants, perf_ld_block;
`endif

    uncache_arbiter_if bus_if ();

    uncache_arbiter #(.OUTS_DEPTH(4), .RR_EN_INIT(0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .rd_rdata     (rd_rdata),
        .sb_req       (sb_req),
        .sb_size      (sb_size),
        .sb_addr      (sb_addr),
        .sb_wdata     (sb_wdata),
        .sb_wstrb     (sb_wstrb),
        .sb_addr_ok   (sb_addr_ok),
        .sb_data_ok   (sb_data_ok),
        .sb_pending   (sb_pending),
        .bus          (bus_if.master)
`ifdef UNCACHE_ARB_PERF_EN
        ,
        .perf_sb_grants (perf_sb_grants),
        .perf_ld_block  (perf_ld_block)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus response: pops the expected source and checks routing and data.
    task automatic resp(input logic [31:0] rd, input logic chk_noreq);
        logic [1:0] e;
        logic [2:0] onehot;
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = rd;
        #1;
        if (chk_noreq) chk("pop_cycle_no_grant", 32'(bus_if.req), 32'd0);
        chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            onehot = (e == SRC_INST) ? 3'b100 : (e == SRC_DATA) ? 3'b010 : 3'b001;
            chk("resp_route", 32'({inst_data_ok, data_data_ok, sb_data_ok}), 32'(onehot));
            chk("resp_rdata", rd_rdata, rd);
        end
        step();
        bus_if.data_ok = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_size = SZ_W; data_addr = '0;
        sb_req = 1'b0; sb_size = SZ_W; sb_addr = '0; sb_wdata = '0; sb_wstrb = '0;
        sb_pending = 1'b0;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;

        // Reset state
        repeat (2) step();
        rstn = 1'b1;
        #1;
        chk("reset_bus_req", 32'(bus_if.req), 32'd0);
        chk("reset_bus_addr", bus_if.addr, 32'd0);
        chk("reset_addr_ok", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'd0);
        chk("reset_data_ok", 32'({inst_data_ok, data_data_ok, sb_data_ok}), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("reset_fifo_empty", 32'(dut.fifo_empty), 32'd1);

        // Simultaneous inst and sb: inst first, sb next, responses in order
        step();
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
        sb_req = 1'b1; sb_addr = 32'h1FAF_0010; sb_wdata = 32'hCAFE_F00D; sb_wstrb = 4'hF;
        bus_if.addr_ok = 1'b1;
        #1;
        chk("t1_inst_wins", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'b100);
        chk("t1_inst_addr", bus_if.addr, 32'h1FC0_0000);
        chk("t1_inst_size", 32'(bus_if.size), 32'(SZ_W));
        chk("t1_inst_rd", 32'(bus_if.wr), 32'd0);
        exp_q.push_back(SRC_INST);
        step();
        inst_req = 1'b0;
        #1;
        chk("t1_sb_wins", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'b001);
        chk("t1_sb_wr", 32'(bus_if.wr), 32'd1);
        chk("t1_sb_wdata", bus_if.wdata, 32'hCAFE_F00D);
        chk("t1_sb_wstrb", 32'(bus_if.wstrb), 32'hF);
        exp_q.push_back(SRC_SB);
        step();
        sb_req = 1'b0; bus_if.addr_ok = 1'b0;
        resp(32'hA5A5_0001, 1'b0);
        resp(32'h0000_0000, 1'b0);

        // Load held behind an unanswered store
        sb_req = 1'b1; sb_addr = 32'h1FAF_0020; sb_wdata = 32'h1357_9BDF; bus_if.addr_ok = 1'b1;
        #1;
        chk("t2_sb_accept", 32'(sb_addr_ok), 32'd1);
        exp_q.push_back(SRC_SB);
        step();
        sb_req = 1'b0; data_req = 1'b1; data_addr = 32'hBFAF_8004; data_size = SZ_H;
        #1;
        chk("t2_ld_blocked", 32'(data_addr_ok), 32'd0);
        chk("t2_ld_blocked_req", 32'(bus_if.req), 32'd0);
        step();
        #1;
        chk("t2_ld_blocked2", 32'(data_addr_ok), 32'd0);
        resp(32'h0000_0000, 1'b1);
        #1;
        chk("t2_ld_grant", 32'(data_addr_ok), 32'd1);
        chk("t2_ld_addr", bus_if.addr, 32'hBFAF_8004);
        chk("t2_ld_size", 32'(bus_if.size), 32'(SZ_H));
        exp_q.push_back(SRC_DATA);
        step();
        data_req = 1'b0; bus_if.addr_ok = 1'b0;
        resp(32'h1234_5678, 1'b0);

        // Grant locked to sb while the bus stalls
        sb_req = 1'b1; sb_addr = 32'h1FAF_0030; sb_wdata = 32'h0BAD_BEEF;
        #1;
        chk("t3_req", 32'(bus_if.req), 32'd1);
        chk("t3_sb_wait", 32'(sb_addr_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            inst_req = 1'b1; inst_addr = 32'h1FC0_0100;
            #1;
            chk("t3_lock_addr", bus_if.addr, 32'h1FAF_0030);
            chk("t3_lock_wdata", bus_if.wdata, 32'h0BAD_BEEF);
            chk("t3_lock_aok", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'd0);
        end
        step();
        bus_if.addr_ok = 1'b1;
        #1;
        chk("t3_sb_accept", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'b001);
        chk("t3_sb_accept_addr", bus_if.addr, 32'h1FAF_0030);
        exp_q.push_back(SRC_SB);
        step();
        sb_req = 1'b0;
        #1;
        chk("t3_inst_after", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'b100);
        chk("t3_inst_addr", bus_if.addr, 32'h1FC0_0100);
        exp_q.push_back(SRC_INST);
        step();
        inst_req = 1'b0; bus_if.addr_ok = 1'b0;
        resp(32'h0000_0000, 1'b0);
        resp(32'h3333_3333, 1'b0);

        // Fill the ID FIFO, then free one slot
        inst_req = 1'b1; bus_if.addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h1FC0_0200 + 32'(i * 4);
            #1;
            chk("t4_fill_accept", 32'(inst_addr_ok), 32'd1);
            exp_q.push_back(SRC_INST);
            step();
        end
        #1;
        chk("t4_full_no_req", 32'(bus_if.req), 32'd0);
        chk("t4_full_no_aok", 32'(inst_addr_ok), 32'd0);
        step();
        #1;
        chk("t4_full_no_req2", 32'(bus_if.req), 32'd0);
        resp(32'h4444_0000, 1'b1);
        #1;
        chk("t4_resume", 32'(inst_addr_ok), 32'd1);
        exp_q.push_back(SRC_INST);
        step();
        inst_req = 1'b0; bus_if.addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp(32'h4444_0001 + 32'(i), 1'b0);
        end

        // Data then inst, responses routed in issue order
        data_req = 1'b1; data_addr = 32'hBFAF_8000; data_size = SZ_W; sb_pending = 1'b1;
        bus_if.addr_ok = 1'b1;
        #1;
        chk("t5_pending_block", 32'(data_addr_ok), 32'd0);
        step();
        sb_pending = 1'b0;
        #1;
        chk("t5_data_accept", 32'(data_addr_ok), 32'd1);
        chk("t5_data_addr", bus_if.addr, 32'hBFAF_8000);
        exp_q.push_back(SRC_DATA);
        step();
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1FC0_0300;
        #1;
        chk("t5_inst_accept", 32'(inst_addr_ok), 32'd1);
        exp_q.push_back(SRC_INST);
        step();
        inst_req = 1'b0; bus_if.addr_ok = 1'b0;
        resp(32'h1111_1111, 1'b0);
        resp(32'h2222_2222, 1'b0);

        // Reset with two reads outstanding and sb locked
        inst_req = 1'b1; bus_if.addr_ok = 1'b1;
        #1;
        chk("t6_acc0", 32'(inst_addr_ok), 32'd1);
        step();
        #1;
        chk("t6_acc1", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0; sb_req = 1'b1; bus_if.addr_ok = 1'b0;
        step();
        #1;
        chk("t6_locked", 32'(dut.state_q), 32'(ARB_LOCK));
        rstn = 1'b0;
        step();
        rstn = 1'b1; sb_req = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("t6_fifo_empty", 32'(dut.fifo_empty), 32'd1);
        chk("t6_addr_ok", 32'({inst_addr_ok, data_addr_ok, sb_addr_ok}), 32'd0);
        chk("t6_data_ok", 32'({inst_data_ok, data_data_ok, sb_data_ok}), 32'd0);
        chk("t6_bus_req", 32'(bus_if.req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
